// File: rtl/spi_flash_pkg.sv
// Shared constants for the SPI NOR flash sequencer: opcodes, status bit
// position, the sequencer state encoding and byte-select helpers.
package spi_flash_pkg;

   localparam logic [7:0] OP_WREN = 8'h06;
   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_PP   = 8'h02;
   localparam logic [7:0] OP_RDSR = 8'h05;

   // Write-in-progress flag inside the flash status register
   localparam int STATUS_WIP = 0;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WREN,
      ST_GAP1,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_GAP2,
      ST_POLL,
      ST_DONE
   } state_t;

   // Address byte idx (0 = most significant) of a 3-byte flash address
   function automatic logic [7:0] addr_byte(input logic [23:0] a, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = a[23:16];
         2'd1:    b = a[15:8];
         default: b = a[7:0];
      endcase
      return b;
   endfunction

   // Data byte idx (0 = most significant) of a 32-bit word
   function automatic logic [7:0] data_byte(input logic [31:0] w, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Two-requester round-robin arbiter. The pointer remembers the port granted
// last; on contention the other port wins. Out of reset port 0 is favoured.
module spi_rr_arbiter (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       en,
   output logic       grant,
   output logic       grant_valid
);

   logic last_reg;

   // Pick the winner: sole requester, or the port not granted last time
   always_comb begin
      grant_valid = en & (req[0] | req[1]);
      grant       = 1'b0;
      if (req[0] && req[1]) begin
         grant = ~last_reg;
      end else begin
         grant = req[1];
      end
   end

   // Remember the most recently granted port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_reg <= 1'b1;
      end else if (grant_valid) begin
         last_reg <= grant;
      end
   end

endmodule

// File: rtl/spi_flash_arbiter_seq.sv
// Shares one SPI NOR flash byte lane between two requesters. Arbitrates
// round-robin in IDLE, then runs a complete READ or WREN/PP/RDSR-poll
// transaction on the 8-bit parallel lane, one byte per clock.
module spi_flash_arbiter_seq
   import spi_flash_pkg::*;
#(
   parameter int ADDR_W   = 24,
   parameter int GAP_CYC  = 2,
   parameter int POLL_MAX = 1024
) (
   input  logic              p_clk,
   input  logic              p_rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [31:0]       wdata0,
   output logic              ack0,
   output logic              err0,
   output logic [31:0]       rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [31:0]       wdata1,
   output logic              ack1,
   output logic              err1,
   output logic [31:0]       rdata1,
   output logic              s_css,
   output logic [7:0]        s_mosi,
   input  logic [7:0]        s_miso
);

   localparam int GAP_W  = $clog2(GAP_CYC + 1);
   localparam int POLL_W = $clog2(POLL_MAX + 1);

   state_t              state_reg;
   logic                port_reg;
   logic                we_reg;
   logic [23:0]         addr_reg;
   logic [31:0]         wdata_reg;
   logic [2:0]          byte_cnt_reg;
   logic [GAP_W-1:0]    gap_cnt_reg;
   logic [POLL_W-1:0]   poll_cnt_reg;
   logic                poll_op_reg;
   logic [23:0]         rx_reg;
   logic                css_reg;
   logic [7:0]          mosi_reg;
   logic                ack0_reg;
   logic                ack1_reg;
   logic                err0_reg;
   logic                err1_reg;
   logic [31:0]         rdata0_reg;
   logic [31:0]         rdata1_reg;

   logic                gnt;
   logic                gnt_valid;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [31:0]         sel_wdata;

   spi_rr_arbiter u_arb (
      .clk         (p_clk),
      .rst         (p_rst),
      .req         ({req1, req0}),
      .en          (state_reg == ST_IDLE),
      .grant       (gnt),
      .grant_valid (gnt_valid)
   );

   // Winner's command fields, captured into the sequencer at grant
   always_comb begin
      sel_we    = gnt ? we1    : we0;
      sel_addr  = gnt ? addr1  : addr0;
      sel_wdata = gnt ? wdata1 : wdata0;
   end

   // Sequencer: every lane output is registered and set on the transition
   // into the state that owns it
   always_ff @(posedge p_clk or posedge p_rst) begin
      if (p_rst) begin
         state_reg    <= ST_IDLE;
         port_reg     <= 1'b0;
         we_reg       <= 1'b0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         byte_cnt_reg <= '0;
         gap_cnt_reg  <= '0;
         poll_cnt_reg <= '0;
         poll_op_reg  <= 1'b0;
         rx_reg       <= '0;
         css_reg      <= 1'b1;
         mosi_reg     <= 8'h00;
         ack0_reg     <= 1'b0;
         ack1_reg     <= 1'b0;
         err0_reg     <= 1'b0;
         err1_reg     <= 1'b0;
         rdata0_reg   <= '0;
         rdata1_reg   <= '0;
      end else begin
         // ack/err are single-cycle pulses raised only on entry to DONE
         ack0_reg <= 1'b0;
         ack1_reg <= 1'b0;
         err0_reg <= 1'b0;
         err1_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               css_reg  <= 1'b1;
               mosi_reg <= 8'h00;
               if (gnt_valid) begin
                  port_reg     <= gnt;
                  we_reg       <= sel_we;
                  addr_reg     <= 24'(sel_addr);
                  wdata_reg    <= sel_wdata;
                  byte_cnt_reg <= '0;
                  css_reg      <= 1'b0;
                  if (sel_we) begin
                     state_reg <= ST_WREN;
                     mosi_reg  <= OP_WREN;
                  end else begin
                     state_reg <= ST_CMD;
                     mosi_reg  <= OP_READ;
                  end
               end
            end
            ST_WREN: begin
               state_reg   <= ST_GAP1;
               css_reg     <= 1'b1;
               mosi_reg    <= 8'h00;
               gap_cnt_reg <= '0;
            end
            ST_GAP1: begin
               if (gap_cnt_reg == GAP_W'(GAP_CYC - 1)) begin
                  state_reg <= ST_CMD;
                  css_reg   <= 1'b0;
                  mosi_reg  <= OP_PP;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg + 1'b1;
               end
            end
            ST_CMD: begin
               state_reg    <= ST_ADDR;
               byte_cnt_reg <= '0;
               mosi_reg     <= addr_byte(addr_reg, 2'd0);
            end
            ST_ADDR: begin
               if (byte_cnt_reg == 3'd2) begin
                  state_reg    <= ST_DATA;
                  byte_cnt_reg <= '0;
                  mosi_reg     <= we_reg ? data_byte(wdata_reg, 2'd0) : 8'h00;
               end else begin
                  byte_cnt_reg <= byte_cnt_reg + 3'd1;
                  mosi_reg     <= addr_byte(addr_reg, byte_cnt_reg[1:0] + 2'd1);
               end
            end
            ST_DATA: begin
               // Read bytes arrive MSB first; keep the first three
               rx_reg <= {rx_reg[15:0], s_miso};
               if (byte_cnt_reg == 3'd3) begin
                  css_reg  <= 1'b1;
                  mosi_reg <= 8'h00;
                  if (we_reg) begin
                     state_reg   <= ST_GAP2;
                     gap_cnt_reg <= '0;
                  end else begin
                     state_reg <= ST_DONE;
                     if (port_reg) begin
                        ack1_reg   <= 1'b1;
                        rdata1_reg <= {rx_reg, s_miso};
                     end else begin
                        ack0_reg   <= 1'b1;
                        rdata0_reg <= {rx_reg, s_miso};
                     end
                  end
               end else begin
                  byte_cnt_reg <= byte_cnt_reg + 3'd1;
                  mosi_reg     <= we_reg ? data_byte(wdata_reg, byte_cnt_reg[1:0] + 2'd1) : 8'h00;
               end
            end
            ST_GAP2: begin
               if (gap_cnt_reg == GAP_W'(GAP_CYC - 1)) begin
                  state_reg    <= ST_POLL;
                  css_reg      <= 1'b0;
                  mosi_reg     <= OP_RDSR;
                  poll_op_reg  <= 1'b1;
                  poll_cnt_reg <= '0;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg + 1'b1;
               end
            end
            ST_POLL: begin
               mosi_reg <= 8'h00;
               if (poll_op_reg) begin
                  // Opcode cycle: no status byte yet
                  poll_op_reg <= 1'b0;
               end else begin
                  if (poll_cnt_reg != POLL_W'(POLL_MAX)) begin
                     poll_cnt_reg <= poll_cnt_reg + 1'b1;
                  end
                  if (!s_miso[STATUS_WIP] || (poll_cnt_reg == POLL_W'(POLL_MAX - 1))) begin
                     state_reg <= ST_DONE;
                     css_reg   <= 1'b1;
                     if (port_reg) begin
                        ack1_reg <= 1'b1;
                        err1_reg <= s_miso[STATUS_WIP];
                     end else begin
                        ack0_reg <= 1'b1;
                        err0_reg <= s_miso[STATUS_WIP];
                     end
                  end
               end
            end
            ST_DONE: begin
               state_reg <= ST_IDLE;
               css_reg   <= 1'b1;
               mosi_reg  <= 8'h00;
            end
            default: begin
               state_reg <= ST_IDLE;
               css_reg   <= 1'b1;
               mosi_reg  <= 8'h00;
            end
         endcase
      end
   end

   assign s_css  = css_reg;
   assign s_mosi = mosi_reg;
   assign ack0   = ack0_reg;
   assign ack1   = ack1_reg;
   assign err0   = err0_reg;
   assign err1   = err1_reg;
   assign rdata0 = rdata0_reg;
   assign rdata1 = rdata1_reg;

endmodule

// File: tb/tb_spi_flash_arbiter_seq.sv
// Bench for spi_flash_arbiter_seq: a behavioural flash on the byte lane, a
// per-port expectation queue filled when requests are issued, and a monitor
// that checks every ack against the queued expectation.
module tb_spi_flash_arbiter_seq;

   localparam int GAP  = 2;
   localparam int PMAX = 4;

   logic        p_clk = 1'b0;
   logic        p_rst = 1'b1;
   logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
   logic [23:0] addr0 = 0, addr1 = 0;
   logic [31:0] wdata0 = 0, wdata1 = 0;
   logic        ack0, err0, ack1, err1;
   logic [31:0] rdata0, rdata1;
   logic        s_css;
   logic [7:0]  s_mosi;
   logic [7:0]  s_miso = 8'h00;

   always #5 p_clk = ~p_clk;

   spi_flash_arbiter_seq #(.ADDR_W(24), .GAP_CYC(GAP), .POLL_MAX(PMAX)) dut (
      .p_clk(p_clk), .p_rst(p_rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .ack0(ack0), .err0(err0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .ack1(ack1), .err1(err1), .rdata1(rdata1),
      .s_css(s_css), .s_mosi(s_mosi), .s_miso(s_miso)
   );

   typedef struct {
      int          port;
      bit          we;
      int          addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      bit          err;
      int          nstat;
      int          start;
      int          lat;
   } exp_t;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   exp_t        exp_q0[$];
   exp_t        exp_q1[$];
   int          ack_log[$];
   logic [31:0] mdl_rd0 = 0, mdl_rd1 = 0;

   // flash model state
   logic [7:0]  fmem[int];
   logic [7:0]  rmem[int];
   logic [7:0]  status_q[$];
   logic [7:0]  obs_q[$];
   int          obs_cmds = 0;
   int          f_idx = 0;
   logic [7:0]  f_op = 0;
   int          f_addr = 0;
   int          gap_cnt = 0;
   bit          seen_cmd = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
      end
   endfunction

   function automatic logic [7:0] dflt(int a);
      return 8'((a * 37 + 11) & 255);
   endfunction

   function automatic logic [7:0] fmem_rd(int a);
      int m = a & 'hFFFFFF;
      return fmem.exists(m) ? fmem[m] : dflt(m);
   endfunction

   function automatic logic [7:0] rmem_rd(int a);
      int m = a & 'hFFFFFF;
      return rmem.exists(m) ? rmem[m] : dflt(m);
   endfunction

   always @(posedge p_clk) cyc <= cyc + 1;

   // Behavioural SPI flash: one byte per chip-select-low cycle
   always @(negedge p_clk) begin
      logic [7:0] miso;
      if (p_rst) begin
         f_idx = 0; obs_q.delete(); obs_cmds = 0; seen_cmd = 0; gap_cnt = 0; s_miso = 8'h00;
      end else if (!s_css) begin
         miso = 8'h00;
         if (f_idx == 0) begin
            if (seen_cmd) check("css_gap", 64'(gap_cnt >= GAP), 1);
            f_op = s_mosi; f_addr = 0; obs_cmds++;
         end else if (f_idx <= 3) begin
            f_addr = (f_addr << 8) | int'(s_mosi);
         end
         obs_q.push_back(s_mosi);
         if (f_op == 8'h03 && f_idx >= 4) miso = fmem_rd(f_addr + f_idx - 4);
         else if (f_op == 8'h05 && f_idx >= 1) miso = (status_q.size() > 0) ? status_q.pop_front() : 8'h00;
         else if (f_op == 8'h02 && f_idx >= 4) fmem[(f_addr + f_idx - 4) & 'hFFFFFF] = s_mosi;
         s_miso = miso;
         f_idx++;
      end else begin
         if (f_idx > 0) begin seen_cmd = 1; gap_cnt = 0; end
         f_idx = 0; gap_cnt++; s_miso = 8'h00;
      end
   end

   // Expected lane traffic of one transaction, from the command definitions
   task automatic handle_ack(input int p);
      exp_t e;
      logic [7:0] eq[$];
      int mis;
      logic [31:0] rd, rd_other, mdl_other;
      logic er;
      rd       = p ? rdata1 : rdata0;
      rd_other = p ? rdata0 : rdata1;
      er       = p ? err1 : err0;
      mdl_other = p ? mdl_rd0 : mdl_rd1;
      ack_log.push_back(p);
      if ((p ? exp_q1.size() : exp_q0.size()) == 0) begin
         check("ack_unexpected", 1, 0);
         return;
      end
      e = p ? exp_q1.pop_front() : exp_q0.pop_front();
      if (e.lat >= 0) check("latency", 64'(cyc - e.start), 64'(e.lat));
      check("err", er, e.err);
      if (!e.we) begin
         check("rdata", rd, e.rdata);
         if (p) mdl_rd1 = e.rdata; else mdl_rd0 = e.rdata;
      end else begin
         check("rdata_prog_hold", rd, p ? mdl_rd1 : mdl_rd0);
      end
      check("rdata_other", rd_other, mdl_other);
      if (e.we) begin
         eq.push_back(8'h06); eq.push_back(8'h02);
      end else begin
         eq.push_back(8'h03);
      end
      for (int i = 2; i >= 0; i--) eq.push_back(8'((e.addr >> (8 * i)) & 255));
      for (int i = 3; i >= 0; i--) eq.push_back(e.we ? e.wdata[8*i +: 8] : 8'h00);
      if (e.we) begin
         eq.push_back(8'h05);
         for (int i = 0; i < e.nstat; i++) eq.push_back(8'h00);
      end
      check("cmd_count", 64'(obs_cmds), e.we ? 3 : 1);
      check("lane_len", 64'(obs_q.size()), 64'(eq.size()));
      mis = -1;
      for (int i = 0; i < eq.size() && i < obs_q.size(); i++) begin
         if (mis < 0 && obs_q[i] !== eq[i]) mis = i;
      end
      if (mis >= 0) begin
         check("lane_byte", obs_q[mis], eq[mis]);
      end else begin
         check("lane_bytes_match", 1, 1 - 64'(obs_q.size() != eq.size()));
      end
      obs_q.delete();
      obs_cmds = 0;
   endtask

   // Monitor: checks every ack and the idle-time invariants of the outputs
   always @(negedge p_clk) begin
      #1;
      if (p_rst) begin
         mdl_rd0 = 0; mdl_rd1 = 0;
      end else begin
         check("ack_exclusive", 64'(ack0 & ack1), 0);
         if (ack0) handle_ack(0);
         else begin
            check("err0_idle", err0, 0);
            check("rdata0_hold", rdata0, mdl_rd0);
         end
         if (ack1) handle_ack(1);
         else begin
            check("err1_idle", err1, 0);
            check("rdata1_hold", rdata1, mdl_rd1);
         end
      end
   end

   task automatic drive(input int p, input bit r, input bit we, input int addr, input logic [31:0] wd);
      if (p == 0) begin req0 = r; we0 = we; addr0 = 24'(addr); wdata0 = wd; end
      else begin req1 = r; we1 = we; addr1 = 24'(addr); wdata1 = wd; end
   endtask

   task automatic wait_ack(input int p);
      int n = 0;
      bit got = 0;
      while (!got && n < 400) begin
         @(negedge p_clk); #2; n++;
         got = (p == 0) ? ack0 : ack1;
      end
      check("ack_seen", got, 1);
   endtask

   function automatic exp_t make_exp(input int p, input bit we, input int addr,
                                     input logic [31:0] wd, input int nstat, input bit tmo, input int lat);
      exp_t e;
      e.port = p; e.we = we; e.addr = addr & 'hFFFFFF; e.wdata = wd; e.err = tmo;
      e.nstat = tmo ? PMAX : nstat; e.start = cyc; e.lat = lat; e.rdata = 0;
      if (!we) for (int i = 0; i < 4; i++) e.rdata[8*(3-i) +: 8] = rmem_rd(addr + i);
      return e;
   endfunction

   // Issue one request, hold it until ack (optionally one cycle longer)
   task automatic txn(input int p, input bit we, input int addr, input logic [31:0] wd,
                      input int nstat, input bit tmo, input int lat, input bit hold);
      exp_t e;
      @(negedge p_clk); #2;
      e = make_exp(p, we, addr, wd, nstat, tmo, lat);
      if (we) begin
         for (int i = 0; i < 4; i++) rmem[(addr + i) & 'hFFFFFF] = wd[8*(3-i) +: 8];
         status_q.delete();
         if (tmo) for (int i = 0; i < PMAX; i++) status_q.push_back(8'($urandom) | 8'h01);
         else begin
            for (int i = 0; i < nstat - 1; i++) status_q.push_back(8'($urandom) | 8'h01);
            status_q.push_back(8'($urandom) & 8'hFE);
         end
      end
      if (p) exp_q1.push_back(e); else exp_q0.push_back(e);
      drive(p, 1, we, addr, wd);
      wait_ack(p);
      if (hold) begin
         // still high in the IDLE cycle: a second identical read follows;
         // change the flash contents so the second result differs
         @(negedge p_clk); #2;
         for (int i = 0; i < 4; i++) begin
            fmem[(addr + i) & 'hFFFFFF] = 8'($urandom);
            rmem[(addr + i) & 'hFFFFFF] = fmem[(addr + i) & 'hFFFFFF];
         end
         e = make_exp(p, we, addr, wd, nstat, tmo, lat);
         if (p) exp_q1.push_back(e); else exp_q0.push_back(e);
         @(negedge p_clk); #2;
         drive(p, 0, we, addr, wd);
         wait_ack(p);
      end
      drive(p, 0, we, addr, wd);
   endtask

   initial begin
      exp_t e;
      int addrs[4];
      // reset state
      repeat (3) @(negedge p_clk);
      check("rst_css", s_css, 1);
      check("rst_mosi", s_mosi, 0);
      check("rst_ack0", ack0, 0);
      check("rst_ack1", ack1, 0);
      check("rst_err0", err0, 0);
      check("rst_err1", err1, 0);
      check("rst_rdata0", rdata0, 0);
      check("rst_rdata1", rdata1, 0);
      #2 p_rst = 0;

      // contention straight after reset: 0, then 1, then a re-issued 0
      fork
         begin
            txn(0, 0, 'h000040, 0, 0, 0, 9, 0);
            txn(0, 0, 'h000080, 0, 0, 0, 19, 0);
         end
         txn(1, 0, 'h0000C0, 0, 0, 0, 19, 0);
      join
      check("rr_order_len", 64'(ack_log.size()), 3);
      if (ack_log.size() == 3) begin
         check("rr_order0", 64'(ack_log[0]), 0);
         check("rr_order1", 64'(ack_log[1]), 1);
         check("rr_order2", 64'(ack_log[2]), 0);
      end

      // directed read
      fmem['h123456] = 8'hDE; fmem['h123457] = 8'hAD; fmem['h123458] = 8'hBE; fmem['h123459] = 8'hEF;
      rmem['h123456] = 8'hDE; rmem['h123457] = 8'hAD; rmem['h123458] = 8'hBE; rmem['h123459] = 8'hEF;
      txn(0, 0, 'h123456, 0, 0, 0, 9, 0);
      check("read_deadbeef", rdata0, 32'hDEADBEEF);

      // directed program, three status bytes, then read it back
      txn(1, 1, 'h000100, 32'hCAFEF00D, 3, 0, 1 + GAP + 8 + GAP + 1 + 3 + 1, 0);
      txn(1, 0, 'h000100, 0, 0, 0, 9, 0);
      check("readback", rdata1, 32'hCAFEF00D);

      // poll timeout, and success on the last allowed status byte
      txn(0, 1, 'h000200, 32'h12345678, 0, 1, 1 + GAP + 8 + GAP + 1 + PMAX + 1, 0);
      txn(0, 1, 'h000204, 32'h87654321, PMAX, 0, 1 + GAP + 8 + GAP + 1 + PMAX + 1, 0);

      // request held one cycle past ack
      txn(0, 0, 'h000300, 0, 0, 0, 9, 1);

      // reset during the address phase of a read, request kept high
      @(negedge p_clk); #2;
      e = make_exp(0, 0, 'h000400, 0, 0, 0, 9);
      exp_q0.push_back(e);
      drive(0, 1, 0, 'h000400, 0);
      repeat (3) @(negedge p_clk);
      #1 p_rst = 1;
      #1;
      check("rst_async_css", s_css, 1);
      check("rst_async_mosi", s_mosi, 0);
      check("rst_async_rdata0", rdata0, 0);
      exp_q0.delete();
      repeat (2) @(posedge p_clk);
      @(negedge p_clk); #2;
      p_rst = 0;
      e = make_exp(0, 0, 'h000400, 0, 0, 0, 9);
      exp_q0.push_back(e);
      wait_ack(0);
      drive(0, 0, 0, 'h000400, 0);

      // randomized solo transactions
      addrs[0] = 'h000100; addrs[1] = 'h123456; addrs[2] = 'hFFFFFE; addrs[3] = 'h000204;
      for (int i = 0; i < 16; i++) begin
         int p, a, ns;
         bit we, tmo;
         p   = int'($urandom_range(0, 1));
         we  = ($urandom_range(0, 2) == 0);
         a   = ($urandom_range(0, 4) == 4) ? int'($urandom & 'hFFFFFF) : addrs[$urandom_range(0, 3)];
         ns  = int'($urandom_range(1, PMAX));
         tmo = we && ($urandom_range(0, 4) == 0);
         txn(p, we, a, $urandom, ns, tmo,
             we ? (1 + GAP + 8 + GAP + 1 + (tmo ? PMAX : ns) + 1) : 9, 0);
      end

      repeat (4) @(negedge p_clk);
      check("left_q0", 64'(exp_q0.size()), 0);
      check("left_q1", 64'(exp_q1.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
